// File: rtl/uart_pkg.sv
// Shared UART types: parity selectors, transmitter FSM states, frame length helper.
// No logic, no latency; consumed by the transmitter and its bench.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int frame_len(input int oversample, input int data_bits,
                                   input int parity_mode, input int stop_bits);
    int par_bits;
    par_bits = (parity_mode != PARITY_NONE) ? 1 : 0;
    return oversample * (1 + data_bits + par_bits + stop_bits);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit period counter: bit_end is high on the last of OVERSAMPLE clocks of each bit.
// Free-running while clear is low, wraps itself at bit_end; no backpressure.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] tick_cnt_q;
  logic [CW-1:0] tick_cnt_d;

  assign bit_end = (tick_cnt_q == LAST_TICK);

  always_comb begin
    tick_cnt_d = tick_cnt_q + CW'(1);
    if (clear || bit_end) begin
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-word holding register; tx falls one clock after an idle handshake.
// din_ready drops while the holding register is full, so back-to-back frames need no idle gap.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  if (OVERSAMPLE < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter combination");
  end

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 par_calc;
  logic                 load;

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == IDLE),
    .bit_end(bit_end)
  );

  assign din_ready = rst_n & ~hold_full_q;
  assign busy      = (state_q != IDLE) | hold_full_q;
  assign tx        = tx_q;
  assign par_calc  = (PARITY_MODE == PARITY_ODD) ? ~^hold_q : ^hold_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    load        = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        load = hold_full_q;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            if (PARITY_MODE != PARITY_NONE) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            tx_d      = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_idx_q == LAST_STOP) begin
            frame_done = rst_n;
            bit_idx_d  = '0;
            state_d    = IDLE;
            load       = hold_full_q;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading also covers the gapless STOP -> START handover.
    if (load) begin
      state_d     = START;
      shift_d     = hold_q;
      par_d       = par_calc;
      hold_full_d = 1'b0;
      bit_idx_d   = '0;
      tx_d        = 1'b0;
    end

    if (din_valid && din_ready) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
    end
  end

endmodule
